// File: rtl/rdyval2reqack_pkg.sv
// Shared types for the ready/valid to req/ack buffer.
package rdyval2reqack_pkg;

  // Output handshake flavour: toggle-per-transfer or return-to-zero.
  typedef enum logic {
    PH_TWO  = 1'b0,
    PH_FOUR = 1'b1
  } phase_mode_e;

  // Output FSM; ST_REQ_OFF is only reachable in PH_FOUR.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ_ON  = 2'd1,
    ST_REQ_OFF = 2'd2
  } state_e;

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchronizer for the returning ack; all flops clear on reset.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  // Shift the raw input in at bit 0; the oldest sample leaves at the top.
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  // Synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rdyval2reqack_buf.sv
// Ready/valid input buffered into a FIFO, drained one word at a time over a
// two- or four-phase req/ack output handshake.
module rdyval2reqack_buf
  import rdyval2reqack_pkg::*;
#(
  parameter int          DWIDTH      = 8,
  parameter int          DEPTH       = 4,
  parameter phase_mode_e PHASE_MODE  = PH_TWO,
  parameter int          SYNC_STAGES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld,
  output logic                       rdy,
  input  logic [DWIDTH-1:0]          i_dat,
  output logic                       req,
  input  logic                       ack,
  output logic [DWIDTH-1:0]          o_dat,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || DWIDTH < 1 ||
      !(SYNC_STAGES == 0 || SYNC_STAGES == 2 || SYNC_STAGES == 3)) begin : g_bad_param
    $error("rdyval2reqack_buf: illegal DEPTH/DWIDTH/SYNC_STAGES");
  end

  // Ack as seen by the FSM: raw, or through the synchronizer chain.
  logic ack_i;
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign ack_i = ack;
  end else begin : g_sync
    hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack),
      .q   (ack_i)
    );
  end

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [DWIDTH-1:0] odat_q, odat_d;
  logic              push, pop;

  // rdy comes straight from the occupancy flop so it never depends on vld.
  assign rdy  = (level_q != LW'(DEPTH));
  assign push = vld && rdy;
  // Pop only from IDLE: the head is read from storage written on an earlier
  // edge, so a word pushed this cycle can never launch on the same edge.
  assign pop  = (state_q == ST_IDLE) && (level_q != '0);

  // Pointer wrap and occupancy update; non power-of-2 DEPTH wraps explicitly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Output FSM next state: launch from IDLE, then wait for the awaited ack edge.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    odat_d  = odat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          odat_d  = mem_q[rd_ptr_q];
          state_d = ST_REQ_ON;
          req_d   = (PHASE_MODE == PH_TWO) ? ~req_q : 1'b1;
        end
      end
      ST_REQ_ON: begin
        if (PHASE_MODE == PH_TWO) begin
          if (ack_i == req_q) state_d = ST_IDLE;
        end else if (ack_i) begin
          req_d   = 1'b0;
          state_d = ST_REQ_OFF;
        end
      end
      ST_REQ_OFF: begin
        if (!ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_dat;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      odat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      req_q    <= req_d;
      odat_q   <= odat_d;
    end
  end

  assign req   = req_q;
  assign o_dat = odat_q;
  assign level = level_q;

endmodule

// File: tb/tb_rdyval2reqack_buf.sv
// Bench for rdyval2reqack_buf: three instances (two-phase, four-phase,
// two-phase with 2-flop ack sync), directed scenarios plus randomized traffic.
module tb_rdyval2reqack_buf;
  import rdyval2reqack_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld   [3];
  logic [7:0] idat  [3];
  logic       ack   [3];
  logic       rdy_o [3];
  logic       req_o [3];
  logic [7:0] odat  [3];
  logic [2:0] lvl   [3];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rdyval2reqack_buf #(.DWIDTH(8), .DEPTH(DEPTH), .PHASE_MODE(PH_TWO), .SYNC_STAGES(0)) u_two (
    .clk(clk), .rst(rst), .vld(vld[0]), .rdy(rdy_o[0]), .i_dat(idat[0]),
    .req(req_o[0]), .ack(ack[0]), .o_dat(odat[0]), .level(lvl[0]));

  rdyval2reqack_buf #(.DWIDTH(8), .DEPTH(DEPTH), .PHASE_MODE(PH_FOUR), .SYNC_STAGES(0)) u_four (
    .clk(clk), .rst(rst), .vld(vld[1]), .rdy(rdy_o[1]), .i_dat(idat[1]),
    .req(req_o[1]), .ack(ack[1]), .o_dat(odat[1]), .level(lvl[1]));

  rdyval2reqack_buf #(.DWIDTH(8), .DEPTH(DEPTH), .PHASE_MODE(PH_TWO), .SYNC_STAGES(2)) u_sync (
    .clk(clk), .rst(rst), .vld(vld[2]), .rdy(rdy_o[2]), .i_dat(idat[2]),
    .req(req_o[2]), .ack(ack[2]), .o_dat(odat[2]), .level(lvl[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0; idat[k] = 8'h00; ack[k] = 1'b0;
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_o[k] !== 1'b0 || lvl[k] !== 3'd0 || odat[k] !== 8'h00 || rdy_o[k] !== 1'b1) begin
        errs++;
        $display("FAIL reset[%0d]: req=%b level=%0d o_dat=%h rdy=%b, want 0/0/00/1",
                 k, req_o[k], lvl[k], odat[k], rdy_o[k]);
      end
    end
    tick();
    checks++;
    if (rdy_o[0] !== 1'b1) begin
      errs++; $display("FAIL rdy_after_reset: rdy=%b want 1", rdy_o[0]);
    end
  endtask

  // Two-phase single transfer with a peer echoing req one cycle later.
  task automatic test_two_basic();
    do_reset();
    vld[0] = 1'b1; idat[0] = 8'hA5;
    tick();
    vld[0] = 1'b0;
    checks++;
    if (req_o[0] !== 1'b0 || lvl[0] !== 3'd1) begin
      errs++; $display("FAIL two_push: req=%b level=%0d want 0/1", req_o[0], lvl[0]);
    end
    tick();
    checks++;
    if (req_o[0] !== 1'b1 || odat[0] !== 8'hA5 || lvl[0] !== 3'd0) begin
      errs++; $display("FAIL two_launch: req=%b o_dat=%h level=%0d want 1/a5/0",
                       req_o[0], odat[0], lvl[0]);
    end
    ack[0] = 1'b1;
    tick(); tick();
    checks++;
    if (req_o[0] !== 1'b1 || odat[0] !== 8'hA5 || lvl[0] !== 3'd0) begin
      errs++; $display("FAIL two_done: req=%b o_dat=%h level=%0d want 1/a5/0",
                       req_o[0], odat[0], lvl[0]);
    end
    // Back in IDLE: a fresh push launches one edge later with req toggling back.
    vld[0] = 1'b1; idat[0] = 8'h3C;
    tick();
    vld[0] = 1'b0;
    tick();
    checks++;
    if (req_o[0] !== 1'b0 || odat[0] !== 8'h3C) begin
      errs++; $display("FAIL two_second: req=%b o_dat=%h want 0/3c", req_o[0], odat[0]);
    end
    ack[0] = 1'b0;
    tick(); tick();
  endtask

  // Four-phase: fill to capacity with ack held low, then watch the RTZ sequence.
  task automatic test_four_full();
    logic [7:0] got [$];
    logic       p_req;
    int         cyc;
    do_reset();
    vld[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idat[1] = 8'(i + 1);
      tick();
    end
    checks++;
    if (rdy_o[1] !== 1'b0 || lvl[1] !== 3'd4 || req_o[1] !== 1'b1 || odat[1] !== 8'h01) begin
      errs++; $display("FAIL four_full: rdy=%b level=%0d req=%b o_dat=%h want 0/4/1/01",
                       rdy_o[1], lvl[1], req_o[1], odat[1]);
    end
    idat[1] = 8'h06;
    tick();
    checks++;
    if (lvl[1] !== 3'd4 || rdy_o[1] !== 1'b0) begin
      errs++; $display("FAIL four_no_overflow: level=%0d rdy=%b want 4/0", lvl[1], rdy_o[1]);
    end
    ack[1] = 1'b1;
    tick();
    checks++;
    if (req_o[1] !== 1'b0 || odat[1] !== 8'h01) begin
      errs++; $display("FAIL four_req_off: req=%b o_dat=%h want 0/01", req_o[1], odat[1]);
    end
    ack[1] = 1'b0;
    tick();
    checks++;
    if (req_o[1] !== 1'b0 || odat[1] !== 8'h01 || lvl[1] !== 3'd4) begin
      errs++; $display("FAIL four_idle: req=%b o_dat=%h level=%0d want 0/01/4",
                       req_o[1], odat[1], lvl[1]);
    end
    tick();
    checks++;
    if (req_o[1] !== 1'b1 || odat[1] !== 8'h02 || lvl[1] !== 3'd3 || rdy_o[1] !== 1'b1) begin
      errs++; $display("FAIL four_relaunch: req=%b o_dat=%h level=%0d rdy=%b want 1/02/3/1",
                       req_o[1], odat[1], lvl[1], rdy_o[1]);
    end
    tick();
    vld[1] = 1'b0;
    checks++;
    if (lvl[1] !== 3'd4) begin
      errs++; $display("FAIL four_refill: level=%0d want 4", lvl[1]);
    end
    // Drain with a peer whose ack follows req; remaining order must be 3..6.
    cyc = 0;
    while (got.size() < 4 && cyc < 200) begin
      ack[1] = req_o[1];
      p_req  = req_o[1];
      tick();
      if (!p_req && req_o[1]) got.push_back(odat[1]);
      cyc++;
    end
    checks++;
    if (got.size() != 4) begin
      errs++; $display("FAIL four_drain_timeout: got %0d words want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 8'(i + 3)) begin
          errs++; $display("FAIL four_order[%0d]: o_dat=%h want %h", i, got[i], 8'(i + 3));
        end
      end
    end
  endtask

  // Two-flop ack sync: completion must lag the ack edge by the chain depth.
  task automatic test_sync_latency();
    do_reset();
    vld[2] = 1'b1; idat[2] = 8'h11;
    tick();
    idat[2] = 8'h22;
    tick();
    vld[2] = 1'b0;
    checks++;
    if (req_o[2] !== 1'b1 || odat[2] !== 8'h11 || lvl[2] !== 3'd1) begin
      errs++; $display("FAIL sync_launch: req=%b o_dat=%h level=%0d want 1/11/1",
                       req_o[2], odat[2], lvl[2]);
    end
    ack[2] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (e < 4) begin
        if (req_o[2] !== 1'b1 || odat[2] !== 8'h11) begin
          errs++; $display("FAIL sync_early[%0d]: req=%b o_dat=%h want 1/11", e, req_o[2], odat[2]);
        end
      end else if (req_o[2] !== 1'b0 || odat[2] !== 8'h22) begin
        errs++; $display("FAIL sync_next: req=%b o_dat=%h want 0/22", req_o[2], odat[2]);
      end
    end
    ack[2] = 1'b0;
    repeat (6) tick();
  endtask

  // Ack wiggles while IDLE must not launch or pop anything.
  task automatic test_spurious();
    do_reset();
    ack[0] = 1'b1; ack[1] = 1'b1;
    tick();
    ack[0] = 1'b0; ack[1] = 1'b0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req_o[k] !== 1'b0 || lvl[k] !== 3'd0 || odat[k] !== 8'h00) begin
        errs++; $display("FAIL spurious[%0d]: req=%b level=%0d o_dat=%h want 0/0/00",
                         k, req_o[k], lvl[k], odat[k]);
      end
    end
  endtask

  // Reset while a transfer is outstanding with two words buffered.
  task automatic test_reset_mid();
    do_reset();
    vld[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idat[0] = 8'hA1 + 8'(i);
      tick();
    end
    vld[0] = 1'b0;
    checks++;
    if (lvl[0] !== 3'd2 || req_o[0] !== 1'b1) begin
      errs++; $display("FAIL mid_setup: level=%0d req=%b want 2/1", lvl[0], req_o[0]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (req_o[0] !== 1'b0 || lvl[0] !== 3'd0 || odat[0] !== 8'h00 || rdy_o[0] !== 1'b1) begin
      errs++; $display("FAIL mid_reset: req=%b level=%0d o_dat=%h rdy=%b want 0/0/00/1",
                       req_o[0], lvl[0], odat[0], rdy_o[0]);
    end
    rst = 1'b0;
    tick();
  endtask

  // Random traffic against a queue scoreboard; the peer echoes req after a
  // random delay, which is a legal responder for both handshake flavours.
  task automatic test_random(input int k, input bit four, input int n);
    logic [7:0] q [$];
    logic       p_vld, p_rdy, p_req, launch;
    logic [7:0] p_dat, p_odat, exp_d;
    do_reset();
    for (int c = 0; c < n + 150; c++) begin
      vld[k]  = (c < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      idat[k] = 8'($urandom);
      if (req_o[k] != ack[k] && $urandom_range(0, 1) == 1) ack[k] = req_o[k];
      p_vld = vld[k]; p_dat = idat[k]; p_rdy = rdy_o[k];
      p_req = req_o[k]; p_odat = odat[k];
      tick();
      launch = four ? (!p_req && req_o[k]) : (p_req != req_o[k]);
      checks++;
      if (launch) begin
        if (q.size() == 0) begin
          errs++; $display("FAIL rnd%0d_empty_launch: cycle %0d o_dat=%h with nothing buffered",
                           k, c, odat[k]);
        end else begin
          exp_d = q.pop_front();
          if (odat[k] !== exp_d) begin
            errs++; $display("FAIL rnd%0d_data: cycle %0d o_dat=%h want %h", k, c, odat[k], exp_d);
          end
        end
      end else if (odat[k] !== p_odat) begin
        errs++; $display("FAIL rnd%0d_stable: cycle %0d o_dat=%h want %h", k, c, odat[k], p_odat);
      end
      if (p_vld && p_rdy) q.push_back(p_dat);
      checks++;
      if (int'(lvl[k]) != q.size() || rdy_o[k] !== (q.size() != DEPTH)) begin
        errs++; $display("FAIL rnd%0d_level: cycle %0d level=%0d rdy=%b want %0d/%b",
                         k, c, lvl[k], rdy_o[k], q.size(), (q.size() != DEPTH));
      end
    end
    checks++;
    if (q.size() != 0) begin
      errs++; $display("FAIL rnd%0d_drain: %0d words undelivered want 0", k, q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0; idat[k] = 8'h00; ack[k] = 1'b0;
    end
    test_reset();
    test_two_basic();
    test_four_full();
    test_sync_latency();
    test_spurious();
    test_reset_mid();
    test_random(0, 1'b0, 400);
    test_random(1, 1'b1, 400);
    test_random(2, 1'b0, 400);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
